// File: rtl/dma_reg_pkg.sv
// rtl/dma_reg_pkg.sv - Register address map and decoded-operation type for the 8237 programming port.
package dma_reg_pkg;

    localparam logic [3:0] ADDR_CMD     = 4'h8;
    localparam logic [3:0] ADDR_REQ     = 4'h9;
    localparam logic [3:0] ADDR_SMASK   = 4'hA;
    localparam logic [3:0] ADDR_MODE    = 4'hB;
    localparam logic [3:0] ADDR_CLRFF   = 4'hC;
    localparam logic [3:0] ADDR_MCLR    = 4'hD;
    localparam logic [3:0] ADDR_CLRMASK = 4'hE;
    localparam logic [3:0] ADDR_ALLMASK = 4'hF;
    localparam logic [3:0] ADDR_STATUS  = 4'h8;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_LOAD_ADDR,
        OP_LOAD_COUNT,
        OP_LOAD_CMD,
        OP_LOAD_REQ,
        OP_LOAD_SMASK,
        OP_LOAD_MODE,
        OP_CLR_FF,
        OP_MCLR,
        OP_CLR_MASK,
        OP_LOAD_ALLMASK,
        OP_READ_ADDR,
        OP_READ_COUNT,
        OP_READ_STATUS
    } dmaOp_t;

    // wr and rd are mutually exclusive by construction, so at most one operation results.
    function automatic dmaOp_t decodeOp(input logic wr, input logic rd, input logic [3:0] a);
        dmaOp_t op;
        op = OP_NONE;
        if (wr) begin
            if (!a[3]) begin
                op = a[0] ? OP_LOAD_COUNT : OP_LOAD_ADDR;
            end else begin
                case (a)
                    ADDR_CMD:     op = OP_LOAD_CMD;
                    ADDR_REQ:     op = OP_LOAD_REQ;
                    ADDR_SMASK:   op = OP_LOAD_SMASK;
                    ADDR_MODE:    op = OP_LOAD_MODE;
                    ADDR_CLRFF:   op = OP_CLR_FF;
                    ADDR_MCLR:    op = OP_MCLR;
                    ADDR_CLRMASK: op = OP_CLR_MASK;
                    ADDR_ALLMASK: op = OP_LOAD_ALLMASK;
                    default:      op = OP_NONE;
                endcase
            end
        end else if (rd) begin
            if (!a[3]) begin
                op = a[0] ? OP_READ_COUNT : OP_READ_ADDR;
            end else if (a == ADDR_STATUS) begin
                op = OP_READ_STATUS;
            end
        end
        return op;
    endfunction

endpackage

// File: rtl/reference_model_ff.sv
// rtl/reference_model_ff.sv - Access-start detect and expected byte-pointer (internal flip-flop).
module reference_model_ff (
    input  logic CLK,
    input  logic RESET,
    input  logic IOW_N,
    input  logic IOR_N,
    input  logic wr,
    input  logic rd,
    input  logic lowBlock,
    input  logic clearFF,
    output logic internalFF
);

    logic prevIOW_N;
    logic prevIOR_N;
    logic iowSeenHigh;
    logic iorSeenHigh;
    logic writeStart;
    logic readStart;

    // A strobe already low when reset releases must rise once before it can start an access.
    assign writeStart = wr & prevIOW_N & iowSeenHigh;
    assign readStart  = rd & prevIOR_N & iorSeenHigh;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prevIOW_N   <= 1'b1;
            prevIOR_N   <= 1'b1;
            iowSeenHigh <= 1'b0;
            iorSeenHigh <= 1'b0;
        end else begin
            prevIOW_N <= IOW_N;
            prevIOR_N <= IOR_N;
            if (IOW_N) begin
                iowSeenHigh <= 1'b1;
            end
            if (IOR_N) begin
                iorSeenHigh <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            internalFF <= 1'b0;
        end else if (clearFF) begin
            internalFF <= 1'b0;
        end else if ((writeStart | readStart) & lowBlock) begin
            internalFF <= ~internalFF;
        end
    end

endmodule

// File: rtl/reference_model.sv
// rtl/reference_model.sv - 8237 CPU programming-port decode model; MASTER_CLEAR_EN adds masterClear.
module reference_model
    import dma_reg_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS_N,
    input  logic       IOR_N,
    input  logic       IOW_N,
    input  logic [3:0] A,
    input  logic       programCondition,
    output logic       loadBaseAddressReg,
    output logic       loadBaseWordCountReg,
    output logic       loadCommandReg,
    output logic       loadRequestReg,
    output logic       loadSingleMask,
    output logic       loadModeReg,
    output logic       clearInternalFF,
    output logic       clearMaskReg,
    output logic       loadAllMask,
    output logic       readCurrentAddressReg,
    output logic       readCurrentWordCountReg,
    output logic       readStatusReg,
    output logic       loadIoDataBufferFromStatus,
    output logic [1:0] channelSel,
    output logic       internalFF,
    output logic       protocolError
`ifdef MASTER_CLEAR_EN
    ,
    output logic       masterClear
`endif
);

    localparam int CH_W = $clog2(NUM_CH);

    logic   sel;
    logic   wr;
    logic   rd;
    logic   clearFF;
    dmaOp_t op;

    assign sel           = programCondition & ~CS_N;
    assign protocolError = sel & ~IOR_N & ~IOW_N;
    // Requiring the opposite strobe high keeps every decode strobe low during a protocol error.
    assign wr            = sel & ~IOW_N & IOR_N;
    assign rd            = sel & ~IOR_N & IOW_N;

    always_comb begin
        op = decodeOp(wr, rd, A);
    end

    assign loadBaseAddressReg         = (op == OP_LOAD_ADDR);
    assign loadBaseWordCountReg       = (op == OP_LOAD_COUNT);
    assign loadCommandReg             = (op == OP_LOAD_CMD);
    assign loadRequestReg             = (op == OP_LOAD_REQ);
    assign loadSingleMask             = (op == OP_LOAD_SMASK);
    assign loadModeReg                = (op == OP_LOAD_MODE);
    assign clearInternalFF            = (op == OP_CLR_FF);
    assign clearMaskReg               = (op == OP_CLR_MASK);
    assign loadAllMask                = (op == OP_LOAD_ALLMASK);
    assign readCurrentAddressReg      = (op == OP_READ_ADDR);
    assign readCurrentWordCountReg    = (op == OP_READ_COUNT);
    assign readStatusReg              = (op == OP_READ_STATUS);
    assign loadIoDataBufferFromStatus = (op == OP_READ_STATUS);

    assign channelSel = A[3] ? 2'b00 : A[CH_W:1];

`ifdef MASTER_CLEAR_EN
    assign masterClear = (op == OP_MCLR);
    assign clearFF     = clearInternalFF | masterClear;
`else
    assign clearFF     = clearInternalFF;
`endif

    reference_model_ff u_ff (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOW_N      (IOW_N),
        .IOR_N      (IOR_N),
        .wr         (wr),
        .rd         (rd),
        .lowBlock   (~A[3]),
        .clearFF    (clearFF),
        .internalFF (internalFF)
    );

endmodule

// File: tb/tb_reference_model.sv
// tb/tb_reference_model.sv - Scoreboard bench for the DMA programming-port decode model.
module tb_reference_model;

    logic       CLK;
    logic       RESET;
    logic       CS_N;
    logic       IOR_N;
    logic       IOW_N;
    logic [3:0] A;
    logic       programCondition;
    logic       loadBaseAddressReg, loadBaseWordCountReg, loadCommandReg, loadRequestReg;
    logic       loadSingleMask, loadModeReg, clearInternalFF, clearMaskReg, loadAllMask;
    logic       readCurrentAddressReg, readCurrentWordCountReg, readStatusReg;
    logic       loadIoDataBufferFromStatus;
    logic [1:0] channelSel;
    logic       internalFF;
    logic       protocolError;
`ifdef MASTER_CLEAR_EN
    logic       masterClear;
`endif

    reference_model #(.NUM_CH(4)) dut (
        .CLK                        (CLK),
        .RESET                      (RESET),
        .CS_N                       (CS_N),
        .IOR_N                      (IOR_N),
        .IOW_N                      (IOW_N),
        .A                          (A),
        .programCondition           (programCondition),
        .loadBaseAddressReg         (loadBaseAddressReg),
        .loadBaseWordCountReg       (loadBaseWordCountReg),
        .loadCommandReg             (loadCommandReg),
        .loadRequestReg             (loadRequestReg),
        .loadSingleMask             (loadSingleMask),
        .loadModeReg                (loadModeReg),
        .clearInternalFF            (clearInternalFF),
        .clearMaskReg               (clearMaskReg),
        .loadAllMask                (loadAllMask),
        .readCurrentAddressReg      (readCurrentAddressReg),
        .readCurrentWordCountReg    (readCurrentWordCountReg),
        .readStatusReg              (readStatusReg),
        .loadIoDataBufferFromStatus (loadIoDataBufferFromStatus),
        .channelSel                 (channelSel),
        .internalFF                 (internalFF),
        .protocolError              (protocolError)
`ifdef MASTER_CLEAR_EN
        ,
        .masterClear                (masterClear)
`endif
    );

    localparam logic [12:0] S_NONE    = 13'h0000;
    localparam logic [12:0] S_ADDR    = 13'h1000;
    localparam logic [12:0] S_COUNT   = 13'h0800;
    localparam logic [12:0] S_CMD     = 13'h0400;
    localparam logic [12:0] S_REQ     = 13'h0200;
    localparam logic [12:0] S_SMASK   = 13'h0100;
    localparam logic [12:0] S_MODE    = 13'h0080;
    localparam logic [12:0] S_CLRFF   = 13'h0040;
    localparam logic [12:0] S_CLRMASK = 13'h0020;
    localparam logic [12:0] S_ALLMASK = 13'h0010;
    localparam logic [12:0] S_RADDR   = 13'h0008;
    localparam logic [12:0] S_RCNT    = 13'h0004;
    localparam logic [12:0] S_STATBUF = 13'h0003;

    typedef struct packed {
        logic        rst;
        logic        pc;
        logic        cs;
        logic        ior;
        logic        iow;
        logic [3:0]  a;
        logic [16:0] exp;
    } row_t;

    logic [16:0] obs;
    logic [16:0] expQ[$];
    int          checks;
    int          failures;

    assign obs = {loadBaseAddressReg, loadBaseWordCountReg, loadCommandReg, loadRequestReg,
                  loadSingleMask, loadModeReg, clearInternalFF, clearMaskReg, loadAllMask,
                  readCurrentAddressReg, readCurrentWordCountReg, readStatusReg,
                  loadIoDataBufferFromStatus, channelSel, internalFF, protocolError};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic row_t mk(input logic rst, input logic pc, input logic cs, input logic ior,
                                input logic iow, input logic [3:0] a, input logic [12:0] str,
                                input logic [1:0] ch, input logic ff, input logic pe);
        row_t r;
        r.rst = rst; r.pc = pc; r.cs = cs; r.ior = ior; r.iow = iow; r.a = a;
        r.exp = {str, ch, ff, pe};
        return r;
    endfunction

    function automatic row_t idle(input logic ff);
        return mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, S_NONE, 2'd0, ff, 1'b0);
    endfunction

    function automatic row_t wrRow(input logic [3:0] a, input logic [12:0] str, input logic [1:0] ch,
                                   input logic ff);
        return mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a, str, ch, ff, 1'b0);
    endfunction

    function automatic row_t rdRow(input logic [3:0] a, input logic [12:0] str, input logic [1:0] ch,
                                   input logic ff);
        return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a, str, ch, ff, 1'b0);
    endfunction

    task automatic applyRow(input row_t r);
        RESET = r.rst; programCondition = r.pc; CS_N = r.cs;
        IOR_N = r.ior; IOW_N = r.iow; A = r.a;
        expQ.push_back(r.exp);
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [16:0] e;
        rows = {mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, S_NONE, 2'd0, 1'b0, 1'b0),
                mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, S_NONE, 2'd0, 1'b0, 1'b0),
                idle(1'b0)};
        foreach (rows[i]) begin
            applyRow(rows[i]);
            @(negedge CLK);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_writes();
        row_t rows[$];
        logic [16:0] e;
        rows = {wrRow(4'h8, S_CMD, 2'd0, 1'b0), idle(1'b0),
                wrRow(4'h4, S_ADDR, 2'd2, 1'b0), idle(1'b1),
                wrRow(4'h4, S_ADDR, 2'd2, 1'b1), idle(1'b0),
                wrRow(4'h0, S_ADDR, 2'd0, 1'b0), idle(1'b1),
                wrRow(4'hC, S_CLRFF, 2'd0, 1'b1), idle(1'b0),
                wrRow(4'h9, S_REQ, 2'd0, 1'b0), idle(1'b0),
                wrRow(4'hA, S_SMASK, 2'd0, 1'b0), idle(1'b0),
                wrRow(4'hB, S_MODE, 2'd0, 1'b0), idle(1'b0),
                wrRow(4'hD, S_NONE, 2'd0, 1'b0), idle(1'b0),
                wrRow(4'hE, S_CLRMASK, 2'd0, 1'b0), idle(1'b0),
                wrRow(4'hF, S_ALLMASK, 2'd0, 1'b0), idle(1'b0),
                wrRow(4'h7, S_COUNT, 2'd3, 1'b0), idle(1'b1),
                wrRow(4'h6, S_ADDR, 2'd3, 1'b1), idle(1'b0)};
        foreach (rows[i]) begin
            applyRow(rows[i]);
            @(negedge CLK);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL writes[%0d] A=%h: got %h expected %h", i, rows[i].a, obs, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reads_protocol();
        row_t rows[$];
        logic [16:0] e;
        rows = {rdRow(4'h8, S_STATBUF, 2'd0, 1'b0), idle(1'b0),
                rdRow(4'h2, S_RADDR, 2'd1, 1'b0), idle(1'b1),
                rdRow(4'h3, S_RCNT, 2'd1, 1'b1), idle(1'b0),
                rdRow(4'h9, S_NONE, 2'd0, 1'b0), idle(1'b0),
                mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, S_NONE, 2'd0, 1'b0, 1'b1),
                mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, S_NONE, 2'd2, 1'b0, 1'b1),
                wrRow(4'h0, S_ADDR, 2'd0, 1'b0), idle(1'b0)};
        foreach (rows[i]) begin
            applyRow(rows[i]);
            @(negedge CLK);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reads_protocol[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_held_and_kill();
        row_t rows[$];
        logic [16:0] e;
        rows = {wrRow(4'h3, S_COUNT, 2'd1, 1'b0), wrRow(4'h3, S_COUNT, 2'd1, 1'b1),
                wrRow(4'h3, S_COUNT, 2'd1, 1'b1), idle(1'b1)};
        for (int k = 0; k < 3; k++) rows.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, S_NONE, 2'd1, 1'b1, 1'b0));
        rows.push_back(idle(1'b1));
        for (int k = 0; k < 3; k++) rows.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, S_NONE, 2'd1, 1'b1, 1'b0));
        rows.push_back(idle(1'b1));
        rows.push_back(wrRow(4'h3, S_COUNT, 2'd1, 1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, S_NONE, 2'd1, 1'b0, 1'b0));
        rows.push_back(wrRow(4'h3, S_COUNT, 2'd1, 1'b0));
        rows.push_back(idle(1'b0));
        foreach (rows[i]) begin
            applyRow(rows[i]);
            @(negedge CLK);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL held_kill[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_access();
        row_t rows[$];
        logic [16:0] e;
        rows = {wrRow(4'h1, S_COUNT, 2'd0, 1'b0),
                mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1, S_COUNT, 2'd0, 1'b0, 1'b0),
                mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1, S_COUNT, 2'd0, 1'b0, 1'b0),
                wrRow(4'h1, S_COUNT, 2'd0, 1'b0), wrRow(4'h1, S_COUNT, 2'd0, 1'b0),
                idle(1'b0),
                wrRow(4'h1, S_COUNT, 2'd0, 1'b0), idle(1'b1),
                wrRow(4'hC, S_CLRFF, 2'd0, 1'b1), idle(1'b0)};
        foreach (rows[i]) begin
            applyRow(rows[i]);
            @(negedge CLK);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_mid[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        RESET = 1'b1; programCondition = 1'b1; CS_N = 1'b0;
        IOR_N = 1'b1; IOW_N = 1'b1; A = 4'h0;
        test_reset();
        test_writes();
        test_reads_protocol();
        test_held_and_kill();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
